gro_sweep_ctrl: RTL
===================

Name: gro_sweep_ctrl

Overview:
Measurement sequencer directly upstream of GRO_TOP. Steps GRO_SEL through every delay line, resets the GRO counter, and gates GRO_EN for a fixed window of CLK cycles. After a settle gap it captures GRO COUNT and hands each result out on a valid/ready port. Replaces testbench-driven sweeps so on-chip logic or a scan/APB wrapper can run the sweep.

Parameters:
SEL_BITS, 3, width of GRO_SEL
DL_NUM, 8, number of delay lines swept (1..2^SEL_BITS)
RPC_BITS, 16, width of GRO COUNT and RES_COUNT
WIN_CYCLES, 4096, CLK cycles GRO_EN is held high per line (>=1)
SETTLE_CYCLES, 4, CLK cycles between GRO_EN fall and COUNT capture (>=2)

Ports:
CLK  in  1  reference clock
RST  in  1  synchronous active-high reset
START  in  1  sweep request, sampled only in IDLE
ABORT  in  1  cancel sweep, any state
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle pulse after last result accepted
GRO_RSTN  out  1  to GRO_TOP RSTN, active-low
GRO_EN  out  1  to GRO_TOP EN
GRO_SEL  out  SEL_BITS  to GRO_TOP SEL
GRO_COUNT  in  RPC_BITS  from GRO_TOP COUNT
RES_VALID  out  1  result available
RES_READY  in  1  consumer accepts result
RES_SEL  out  SEL_BITS  delay line of current result
RES_COUNT  out  RPC_BITS  captured count
RES_SAT  out  1  captured count == all ones (window too long / overflow)

Behaviour:
- Reset (RST=1 at posedge): state IDLE; BUSY=0, DONE=0, GRO_RSTN=0, GRO_EN=0, GRO_SEL=0, RES_VALID=0, RES_SEL=0, RES_COUNT=0, RES_SAT=0; window/settle counters 0. All outputs registered.
- States: IDLE, CLR, MEAS, SETTLE, CAPT, OUT.
- IDLE: GRO_RSTN=0, GRO_EN=0. START=1 -> CLR, GRO_SEL=0.
- CLR: GRO_RSTN=0 for exactly 2 cycles -> MEAS.
- MEAS: GRO_RSTN=1, GRO_EN=1 for exactly WIN_CYCLES consecutive cycles (counter 0..WIN_CYCLES-1) -> SETTLE.
- SETTLE: GRO_EN=0 for exactly SETTLE_CYCLES cycles; lets async ring counter stop before sampling -> CAPT.
- CAPT: 1 cycle; RES_COUNT<=GRO_COUNT, RES_SEL<=GRO_SEL, RES_SAT<=(GRO_COUNT=={RPC_BITS{1}}) -> OUT; RES_VALID=1 from first OUT cycle.
- OUT: RES_VALID, RES_COUNT, RES_SEL, RES_SAT held stable until RES_VALID&&RES_READY. On handshake RES_VALID=0 next cycle, then:
  - GRO_SEL==DL_NUM-1: DONE=1 one cycle, GRO_SEL<=0 -> IDLE.
  - else GRO_SEL<=GRO_SEL+1 -> CLR.
- RES_READY=1 already on entry to OUT: handshake on first OUT cycle (no extra stall).
- Per-line latency START/handshake to RES_VALID: 2+WIN_CYCLES+SETTLE_CYCLES+1 cycles.
- START while BUSY ignored. START and ABORT same cycle in IDLE: ABORT wins, stay IDLE.
- ABORT (any non-IDLE state): next cycle IDLE, GRO_EN=0, GRO_RSTN=0, RES_VALID=0, GRO_SEL=0, no DONE. RES_COUNT/RES_SEL keep last captured value.
- RST overrides ABORT and everything else.
- GRO_SEL never exceeds DL_NUM-1; DL_NUM=1 sweeps single line.

Test Plan:
- Default params, START one cycle, RES_READY=1, GRO model of period 1.5xCLK -> 8 results, RES_SEL 0..7 in order, RES_COUNT ~2730 each, GRO_EN high exactly 4096 cycles per line, DONE pulses once, BUSY falls same cycle as DONE.
- WIN_CYCLES=16, RES_READY held 0 for 20 cycles at line 3 -> RES_VALID/RES_COUNT/RES_SEL=3 stable all 20 cycles, GRO_EN stays 0, line 4 CLR starts cycle after handshake.
- Count saturation: RPC_BITS=8, WIN_CYCLES=1024, fast GRO -> RES_COUNT=255, RES_SAT=1.
- ABORT during MEAS of line 2 -> next cycle GRO_EN=0, GRO_RSTN=0, BUSY=0, GRO_SEL=0, no DONE; new START restarts at line 0.
- START pulsed while BUSY and START+ABORT in IDLE -> no restart / stays IDLE.
- RST asserted in OUT with RES_VALID=1 -> all outputs reset values next cycle, including RES_COUNT=0.

Source files
------------

// File: rtl/gro_sweep_ctrl.sv
// gro_sweep_ctrl: measurement sequencer sitting directly upstream of GRO_TOP.
// It walks gro_sel through every delay line. For each line it clears the ring
// counter, opens a fixed gro_en window, waits for the asynchronous counter to
// stop, captures the count, and offers the result on a valid/ready port.
// All outputs come straight from flops.
module gro_sweep_ctrl #(
    parameter int SEL_BITS      = 3,
    parameter int DL_NUM        = 8,
    parameter int RPC_BITS      = 16,
    parameter int WIN_CYCLES    = 4096,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                gro_rstn,
    output logic                gro_en,
    output logic [SEL_BITS-1:0] gro_sel,
    input  logic [RPC_BITS-1:0] gro_count,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [SEL_BITS-1:0] res_sel,
    output logic [RPC_BITS-1:0] res_count,
    output logic                res_sat
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_MEAS   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_CAPT   = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;

    // The ring counter reset is held low for two reference cycles.
    localparam int CLR_CYCLES = 2;

    // One shared phase counter is sized for the longest timed phase.
    localparam int CNT_MAX0 = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > CLR_CYCLES) ? CNT_MAX0 : CLR_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]    WIN_LAST    = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_BITS-1:0] SEL_LAST    = SEL_BITS'(DL_NUM - 1);
    localparam logic [RPC_BITS-1:0] COUNT_FULL  = {RPC_BITS{1'b1}};

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [SEL_BITS-1:0] sel_nxt;
    logic                done_nxt;
    logic                handshake;

    assign handshake = (state == ST_OUT) && res_valid && res_ready;

    // Next-state, phase counter and line-select sequencing; abort overrides everything except reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = gro_sel;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_CLR;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                end
            end
            ST_CLR: begin
                if (cnt == CLR_LAST) begin
                    state_nxt = ST_MEAS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (cnt == WIN_LAST) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = ST_CAPT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (handshake) begin
                    cnt_nxt = '0;
                    if (gro_sel == SEL_LAST) begin
                        state_nxt = ST_IDLE;
                        sel_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_CLR;
                        sel_nxt   = gro_sel + SEL_BITS'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                sel_nxt   = '0;
            end
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    // Register the state and derive every GRO-facing strobe from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gro_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gro_en    <= 1'b0;
            gro_rstn  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gro_sel   <= sel_nxt;
            busy      <= (state_nxt != ST_IDLE);
            done      <= done_nxt;
            gro_en    <= (state_nxt == ST_MEAS);
            gro_rstn  <= (state_nxt != ST_IDLE) && (state_nxt != ST_CLR);
            res_valid <= (state_nxt == ST_OUT);
        end
    end

    // Capture the frozen ring count once it has settled; the result is held until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            res_sel   <= '0;
            res_count <= '0;
            res_sat   <= 1'b0;
        end else if ((state == ST_CAPT) && !abort) begin
            res_sel   <= gro_sel;
            res_count <= gro_count;
            res_sat   <= (gro_count == COUNT_FULL);
        end
    end

endmodule
